// File: rtl/sqd_channel_scheduler_if.sv
// Handshake bundle for the shared serial pattern detector: per-channel bit inputs
// with grants, plus the one-deep match event port.
interface sqd_channel_scheduler_if #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
);
    logic            ENABLE;
    logic [N_CH-1:0] IN_VALID;
    logic [N_CH-1:0] IN_BIT;
    logic [N_CH-1:0] IN_READY;
    logic [N_CH-1:0] CLEAR_CH;
    logic            MATCH_VALID;
    logic            MATCH_READY;
    logic [CH_W-1:0] MATCH_CH;
    logic [15:0]     MATCH_TOTAL;

    modport master (
        output ENABLE, IN_VALID, IN_BIT, CLEAR_CH, MATCH_READY,
        input  IN_READY, MATCH_VALID, MATCH_CH, MATCH_TOTAL
    );

    modport slave (
        input  ENABLE, IN_VALID, IN_BIT, CLEAR_CH, MATCH_READY,
        output IN_READY, MATCH_VALID, MATCH_CH, MATCH_TOTAL
    );
endinterface

// File: rtl/sqd_channel_scheduler.sv
// One serial sequence detector time-shared across N_CH channels via a round-robin
// grant, with per-channel saved history and a one-deep tagged match output stage.
module sqd_channel_scheduler #(
    parameter int                 N_CH    = 4,
    parameter int                 CH_W    = 2,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101
) (
    input  logic                   CLK,
    input  logic                   RESET,
    sqd_channel_scheduler_if.slave bus
);
    localparam int                CNT_W   = $clog2(PAT_LEN);
    localparam int                HIST_W  = PAT_LEN - 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PAT_LEN - 1);

    typedef enum logic {EMPTY, FULL} out_state_t;

    out_state_t         state_p1;
    logic [CH_W-1:0]    match_ch_p1;
    logic [15:0]        total;

    logic [HIST_W-1:0]  hist [N_CH];
    logic [CNT_W-1:0]   cnt  [N_CH];
    logic [CH_W-1:0]    rr;

    logic [N_CH-1:0]    cand;
    logic [N_CH-1:0]    gnt;
    logic [CH_W-1:0]    gnt_idx;
    logic [CH_W-1:0]    idx;
    logic               gnt_any;
    logic               can_accept;
    logic               accept;
    logic               hit;
    logic [PAT_LEN-1:0] win;

    // A cleared channel is never a candidate, so clear always beats grant.
    assign cand       = bus.IN_VALID & ~bus.CLEAR_CH;
    assign accept     = (state_p1 == FULL) && bus.MATCH_READY;
    assign can_accept = bus.ENABLE && ((state_p1 == EMPTY) || bus.MATCH_READY);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        if (can_accept) begin
            for (int k = 1; k <= N_CH; k++) begin
                idx = CH_W'((int'(rr) + k) % N_CH);
                if (!gnt_any && cand[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx;
                end
            end
        end
        if (gnt_any)
            gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        win = {hist[gnt_idx], bus.IN_BIT[gnt_idx]};
        hit = gnt_any && (cnt[gnt_idx] == CNT_MAX) && (win == PATTERN);
    end

    // p0 -> p1: per-channel context write-back and arbitration pointer
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N_CH; i++) begin
                hist[i] <= '0;
                cnt[i]  <= '0;
            end
            rr <= CH_W'(N_CH - 1);
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.CLEAR_CH[i]) begin
                    hist[i] <= '0;
                    cnt[i]  <= '0;
                end else if (gnt[i]) begin
                    hist[i] <= win[HIST_W-1:0];
                    if (cnt[i] != CNT_MAX)
                        cnt[i] <= cnt[i] + 1'b1;
                end
            end
            if (gnt_any)
                rr <= gnt_idx;
        end
    end

    // p1: output stage; a hit can only occur in FULL when the held event is taken
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_p1    <= EMPTY;
            match_ch_p1 <= '0;
            total       <= '0;
        end else begin
            if (accept)
                total <= total + 16'd1;
            case (state_p1)
                EMPTY: begin
                    if (hit) begin
                        state_p1    <= FULL;
                        match_ch_p1 <= gnt_idx;
                    end
                end
                FULL: begin
                    if (bus.MATCH_READY) begin
                        if (hit)
                            match_ch_p1 <= gnt_idx;
                        else
                            state_p1 <= EMPTY;
                    end
                end
                default: state_p1 <= EMPTY;
            endcase
        end
    end

    assign bus.IN_READY    = gnt;
    assign bus.MATCH_VALID = (state_p1 == FULL);
    assign bus.MATCH_CH    = match_ch_p1;
    assign bus.MATCH_TOTAL = total;
endmodule
